alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one vALU datapath (the 5-input result mux and its operation units) among NREQ requesters.
//  - Arbitrates round-robin and latches the winner's operands and opcode.
//  - Drives the ALU's ctl select and operands for LAT cycles, then captures the result.
//  - Returns the result to the winner over a valid/ready response.
//  - Sits between the CPU issue stage and the vALU.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  WIDTH  32  operand/result width
//  CTL_W  4   ALU control width
//  LAT    2   cycles the ALU needs, from stable operands to valid result (1..15)
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           asynchronous, active-high reset
//  req_valid   in   NREQ        per-requester request valid
//  req_ready   out  NREQ        one-hot grant/accept; at most one bit set
//  req_op      in   NREQ*CTL_W  packed opcodes; requester i at [i*CTL_W +: CTL_W]
//  req_a       in   NREQ*WIDTH  packed operand A
//  req_b       in   NREQ*WIDTH  packed operand B
//  alu_ctl     out  CTL_W       select driven to the ALU result mux
//  alu_a       out  WIDTH       operand A to the ALU
//  alu_b       out  WIDTH       operand B to the ALU
//  alu_result  in   WIDTH       ALU output
//  rsp_valid   out  NREQ        one-hot response valid, to the owner only
//  rsp_ready   in   NREQ        per-requester response ready
//  rsp_data    out  WIDTH       response result, shared bus
//  rsp_err     out  1           illegal opcode flag, qualified by rsp_valid
//  busy        out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr_ptr 0; the latched op, operands, owner and result are 0.
//  Reset mid-operation: the in-flight operation is dropped silently and no response is issued.
//  FSM states: IDLE, EXEC, RESP.
//  IDLE:
//   - req_ready is combinational. It is one-hot for the first valid requester at or after rr_ptr, wrapping modulo NREQ.
//   - On handshake T: latch op, a, b and owner; rr_ptr <= owner+1 (mod NREQ).
//   - Legal op (0..4): go to EXEC with cnt <= LAT-1.
//   - Illegal op (5..15): go directly to RESP with rsp_data=0 and rsp_err=1; the ALU is not exercised.
//  EXEC:
//   - alu_ctl, alu_a and alu_b are driven from the latched registers and held stable.
//   - Outside EXEC, alu_ctl, alu_a and alu_b are 0.
//   - cnt decrements each cycle.
//   - When cnt==0: capture alu_result into the response register and go to RESP.
//   - rsp_valid[owner] rises at cycle T+1+LAT.
//  RESP:
//   - rsp_valid[owner]=1 and rsp_data/rsp_err are held until rsp_ready[owner]=1. Then go to IDLE.
//   - rsp_ready bits of non-owners are ignored.
//   - req_ready is all 0 in EXEC and RESP; there is no overlap of operations.
//  Throughput: one operation per LAT+2 cycles at best, since the grant only happens in IDLE.
//  Fairness: a continuously requesting requester waits for at most NREQ-1 other operations.
//  Simultaneous requests: the rr_ptr order decides; ties cannot occur.
//  Behaviour when req_valid drops without a handshake is legal. Requests carry no ordering obligation.
//  Width rules: no arithmetic on data; cnt is 4 bits, and owner and rr_ptr are clog2(NREQ) bits.
// STRUCTURE
//  Shared package/include (valu_pkg.v):
//   - ALU op codes: OP_ADD=0, OP_SUB=1, OP_XOR=2, OP_SLT=3, OP_NAND=4 (mux inputs I0..I4).
//   - OP_MAX=4.
//   - FSM state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
//  Sub-module rr_arbiter (NREQ): inputs req and ptr; outputs one-hot gnt and index. Purely combinational.
//  All sequential logic (FSM, cnt, latches, rr_ptr) lives in alu_share_arbiter.
// TESTING
//  1. Reset then idle:
//     - Hold rst 3 cycles with req_valid=4'b1111.
//     - Expect all outputs 0 and no req_ready.
//     - After rst drops, grant 4'b0001.
//  2. Single operation, LAT=2:
//     - Requester 2 sends op=0, a=5, b=7; the ALU model returns a+b.
//     - Expect alu_ctl=0 for 2 cycles, then rsp_valid=4'b0100 at T+3 with rsp_data=12 and rsp_err=0.
//  3. Round robin:
//     - All 4 request continuously with rsp_ready=1.
//     - Expect grant order 0,1,2,3,0 and a grant every LAT+2 cycles.
//  4. Backpressure:
//     - Hold rsp_ready=0 for 5 cycles.
//     - Expect rsp_valid and rsp_data stable, req_ready=0 and busy=1.
//     - Expect release one cycle after ready.
//  5. Illegal op:
//     - Requester 1 sends op=9.
//     - Expect no EXEC (alu_ctl stays 0), and rsp_valid=4'b0010 at T+1 with rsp_err=1 and rsp_data=0.
//  6. Reset mid-operation:
//     - Assert rst during EXEC.
//     - Expect an immediate async clear, no response for the dropped operation, and rr_ptr back to 0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the vALU sharing block.
//  - ALU op codes, which are also the result-mux input indices I0..I4.
//  - The FSM state encoding of the arbiter.
package alu_share_arbiter_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_SLT  = 3;
  localparam int OP_NAND = 4;
  localparam int OP_MAX  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//  req : request vector
//  ptr : highest-priority index
//  gnt : one-hot grant for the first set req bit at or after ptr, wrapping
//  idx : binary index of gnt (0 when nothing is requested)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one vALU datapath among NREQ requesters.
// A round-robin grant in IDLE latches the winner's opcode and operands,
// the ALU is driven with them for LAT cycles, and the result is returned to
// the winner over a one-hot valid/ready response.
//  clk, rst              clock, asynchronous active-high reset
//  req_valid/ready       per-requester request handshake (ready one-hot)
//  req_op/a/b            packed per-requester opcode and operands
//  alu_ctl/a/b           ALU drive, non-zero only while executing
//  alu_result            ALU output, captured on the last execute cycle
//  rsp_valid/ready       one-hot response handshake to the owner
//  rsp_data, rsp_err     response payload; rsp_err marks an illegal opcode
//  busy                  high whenever an operation is in flight
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int CTL_W = 4,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*CTL_W-1:0]   req_op,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [CTL_W-1:0]        alu_ctl,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  input  logic [WIDTH-1:0]        alu_result,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [CTL_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic               err_q, err_d;
  logic [IW-1:0]      owner_q, owner_d, ptr_q, ptr_d;

  logic [NREQ-1:0]    gnt;
  logic [IW-1:0]      gnt_idx;
  logic [CTL_W-1:0]   sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign sel_op = req_op[gnt_idx*CTL_W +: CTL_W];
  assign sel_a  = req_a[gnt_idx*WIDTH +: WIDTH];
  assign sel_b  = req_b[gnt_idx*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        // Any valid request is granted this cycle since ready is combinational.
        if (|req_valid) begin
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          owner_d = gnt_idx;
          ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (sel_op > CTL_W'(OP_MAX)) begin
            // Illegal op skips the ALU and answers with an error next cycle.
            res_d   = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = 4'(LAT - 1);
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_result;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // rst gates the only combinational output so nothing is granted during reset.
  assign req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
  assign alu_ctl   = (state_q == ST_EXEC) ? op_q : '0;
  assign alu_a     = (state_q == ST_EXEC) ? a_q  : '0;
  assign alu_b     = (state_q == ST_EXEC) ? b_q  : '0;
  assign rsp_valid = (state_q == ST_RESP) ? (NREQ'(1) << owner_q) : '0;
  assign rsp_data  = (state_q == ST_RESP) ? res_q : '0;
  assign rsp_err   = (state_q == ST_RESP) ? err_q : 1'b0;
  assign busy      = (state_q != ST_IDLE);

endmodule
